// File: rtl/ad7124_measure_sched.sv
// rtl/ad7124_measure_sched.sv - PPS-divided measurement trigger sequencer for the AD7124 acquisition core
// Optional feature macro: AD7124_SCHED_SW_TRIG_EN adds the sw_trig input.
module ad7124_measure_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 100000000,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic                 pps_in,
    input  logic [7:0]           period_sec,
    input  logic [31:0]          rtc_sec,
    input  logic [31:0]          rtc_nsec,
    input  logic                 clear_cnt,
`ifdef AD7124_SCHED_SW_TRIG_EN
    input  logic                 sw_trig,
`endif
    output logic                 measure_start,
    input  logic                 measure_ready,
    input  logic                 measure_done,
    output logic                 busy,
    output logic [31:0]          ts_sec,
    output logic [31:0]          ts_nsec,
    output logic                 ts_valid,
    output logic [CNT_WIDTH-1:0] overrun_cnt,
    output logic [CNT_WIDTH-1:0] timeout_cnt
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [2:0]           pps_sync_q;
    logic [7:0]           pps_div_q, pps_div_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [31:0]          shadow_sec_q, shadow_sec_d, shadow_nsec_q, shadow_nsec_d;
    logic [31:0]          ts_sec_q, ts_sec_d, ts_nsec_q, ts_nsec_d;
    logic                 ts_valid_q, ts_valid_d;
    logic [CNT_WIDTH-1:0] ovr_q, ovr_d, tcnt_q, tcnt_d;
    logic                 pps_rise, pps_tick, pps_trig, trig, timeout_evt;
    logic [7:0]           pps_lim;

    // Bits [1:0] form the synchronizer; bit 2 is the edge-detect history.
    assign pps_rise = pps_sync_q[1] & ~pps_sync_q[2];
    assign pps_lim  = (period_sec == 8'd0) ? 8'd0 : period_sec - 8'd1;
    assign pps_tick = pps_rise & enable;
    // >= rather than == so a shrinking period_sec cannot strand the divider above the limit.
    assign pps_trig = pps_tick & (pps_div_q >= pps_lim);

`ifdef AD7124_SCHED_SW_TRIG_EN
    assign trig = pps_trig | sw_trig;
`else
    assign trig = pps_trig;
`endif

    always_comb begin
        pps_div_d = pps_div_q;
        if (!enable) begin
            pps_div_d = 8'd0;
        end else if (pps_tick) begin
            pps_div_d = pps_trig ? 8'd0 : pps_div_q + 8'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmo_d         = tmo_q;
        shadow_sec_d  = shadow_sec_q;
        shadow_nsec_d = shadow_nsec_q;
        ts_sec_d      = ts_sec_q;
        ts_nsec_d     = ts_nsec_q;
        ts_valid_d    = 1'b0;
        timeout_evt   = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (trig) state_d = S_START;
            end
            S_START: begin
                tmo_d = tmo_q + TW'(1);
                if (measure_ready) begin
                    shadow_sec_d  = rtc_sec;
                    shadow_nsec_d = rtc_nsec;
                    state_d       = measure_done ? S_DONE : S_RUN;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_evt = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_RUN: begin
                tmo_d = tmo_q + TW'(1);
                if (measure_done) begin
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_evt = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_DONE: begin
                ts_sec_d   = shadow_sec_q;
                ts_nsec_d  = shadow_nsec_q;
                ts_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating counters; a clear wins over a coincident increment.
    always_comb begin
        ovr_d  = ovr_q;
        tcnt_d = tcnt_q;
        if (clear_cnt) begin
            ovr_d  = '0;
            tcnt_d = '0;
        end else begin
            if (trig && (state_q != S_IDLE) && !(&ovr_q)) ovr_d = ovr_q + CNT_WIDTH'(1);
            if (timeout_evt && !(&tcnt_q)) tcnt_d = tcnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            pps_sync_q    <= 3'b000;
            pps_div_q     <= 8'd0;
            tmo_q         <= '0;
            shadow_sec_q  <= 32'd0;
            shadow_nsec_q <= 32'd0;
            ts_sec_q      <= 32'd0;
            ts_nsec_q     <= 32'd0;
            ts_valid_q    <= 1'b0;
            ovr_q         <= '0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            pps_sync_q    <= {pps_sync_q[1:0], pps_in};
            pps_div_q     <= pps_div_d;
            tmo_q         <= tmo_d;
            shadow_sec_q  <= shadow_sec_d;
            shadow_nsec_q <= shadow_nsec_d;
            ts_sec_q      <= ts_sec_d;
            ts_nsec_q     <= ts_nsec_d;
            ts_valid_q    <= ts_valid_d;
            ovr_q         <= ovr_d;
            tcnt_q        <= tcnt_d;
        end
    end

    assign measure_start = (state_q == S_START);
    assign busy          = (state_q != S_IDLE);
    assign ts_sec        = ts_sec_q;
    assign ts_nsec       = ts_nsec_q;
    assign ts_valid      = ts_valid_q;
    assign overrun_cnt   = ovr_q;
    assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_ad7124_measure_sched.sv
// tb/tb_ad7124_measure_sched.sv - directed self-checking bench for ad7124_measure_sched
module tb_ad7124_measure_sched;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        pps_in = 1'b0;
    logic [7:0]  period_sec = 8'd1;
    logic [31:0] rtc_sec = 32'd0;
    logic [31:0] rtc_nsec = 32'd0;
    logic        clear_cnt = 1'b0;
`ifdef AD7124_SCHED_SW_TRIG_EN
    logic        sw_trig = 1'b0;
`endif
    logic        measure_start;
    logic        measure_ready = 1'b0;
    logic        measure_done = 1'b0;
    logic        busy;
    logic [31:0] ts_sec, ts_nsec;
    logic        ts_valid;
    logic [1:0]  overrun_cnt, timeout_cnt;

    int          n_assert = 0;
    int          n_fail = 0;
    int          starts = 0;
    int          tsv = 0;
    int          core_cnt = 0;
    int          cyc = 0;
    int          s0, v0;
    logic        start_prev = 1'b0;
    logic        no_done = 1'b0;
    logic [31:0] exp_sec = 32'd0;
    logic [31:0] exp_nsec = 32'd0;

    always #5 aclk = ~aclk;

    ad7124_measure_sched #(.TIMEOUT_CYCLES(50), .CNT_WIDTH(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .pps_in(pps_in),
        .period_sec(period_sec), .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec),
        .clear_cnt(clear_cnt),
`ifdef AD7124_SCHED_SW_TRIG_EN
        .sw_trig(sw_trig),
`endif
        .measure_start(measure_start), .measure_ready(measure_ready),
        .measure_done(measure_done), .busy(busy), .ts_sec(ts_sec),
        .ts_nsec(ts_nsec), .ts_valid(ts_valid), .overrun_cnt(overrun_cnt),
        .timeout_cnt(timeout_cnt)
    );

    // Core model: ready 4 cycles after start is seen, done 20 cycles after; RTC advances every cycle.
    always @(negedge aclk) begin
        cyc++;
        rtc_sec       = 32'(cyc);
        rtc_nsec      = 32'(cyc * 7 + 3);
        measure_ready = 1'b0;
        measure_done  = 1'b0;
        if (!aresetn) begin
            core_cnt = 0;
        end else if (measure_start || core_cnt != 0) begin
            core_cnt++;
            if (core_cnt == 4) begin
                measure_ready = 1'b1;
                exp_sec       = rtc_sec;
                exp_nsec      = rtc_nsec;
            end
            if (core_cnt == 20) begin
                if (!no_done) measure_done = 1'b1;
                core_cnt = 0;
            end
        end
    end

    always @(posedge aclk) begin
        #1;
        if (measure_start && !start_prev) starts++;
        start_prev = measure_start;
        if (ts_valid) tsv++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pps_pulse(input int gap);
        pps_in = 1'b1;
        tick(3);
        pps_in = 1'b0;
        tick(gap);
    endtask

    task automatic wait_tsv(input string tag);
        int n;
        n = 0;
        while (ts_valid !== 1'b1 && n < 80) begin
            tick(1);
            n++;
        end
        chk({tag, "_valid"}, ts_valid, 1);
        chk({tag, "_sec"}, ts_sec, exp_sec);
        chk({tag, "_nsec"}, ts_nsec, exp_nsec);
    endtask

    initial begin
        tick(3);
        chk("rst_start", measure_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tsv", ts_valid, 0);
        chk("rst_ts_sec", ts_sec, 0);
        chk("rst_ts_nsec", ts_nsec, 0);
        chk("rst_ovr", overrun_cnt, 0);
        chk("rst_tmo", timeout_cnt, 0);
        aresetn = 1'b1;
        enable  = 1'b1;
        tick(2);

        // period 1: three measurements, first one with latency checks
        pps_in = 1'b1;
        tick(2);
        chk("lat_start_early", measure_start, 0);
        tick(1);
        chk("lat_start", measure_start, 1);
        chk("lat_busy", busy, 1);
        pps_in = 1'b0;
        wait_tsv("m1");
        tick(10);
        for (int i = 0; i < 2; i++) begin
            pps_in = 1'b1;
            tick(3);
            pps_in = 1'b0;
            wait_tsv("mN");
            tick(10);
        end
        chk("p1_starts", starts, 3);
        chk("p1_tsv", tsv, 3);
        chk("p1_ovr", overrun_cnt, 0);
        chk("p1_tmo", timeout_cnt, 0);

        // period 3: starts on pulses 3 and 6 of 7; then period 0 acts as 1
        period_sec = 8'd3;
        s0 = starts;
        pps_pulse(27);
        pps_pulse(27);
        chk("p3_after2", starts, s0);
        pps_pulse(27);
        chk("p3_after3", starts, s0 + 1);
        repeat (4) pps_pulse(27);
        chk("p3_after7", starts, s0 + 2);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        period_sec = 8'd0;
        pps_pulse(27);
        pps_pulse(27);
        chk("p0_starts", starts, s0 + 4);

        // timeout: core never finishes
        period_sec = 8'd1;
        no_done = 1'b1;
        v0 = tsv;
        pps_in = 1'b1;
        tick(3);
        chk("tmo_start", measure_start, 1);
        pps_in = 1'b0;
        tick(49);
        chk("tmo_busy_last", busy, 1);
        chk("tmo_start_dropped", measure_start, 0);
        tick(1);
        chk("tmo_idle", busy, 0);
        chk("tmo_cnt", timeout_cnt, 1);
        chk("tmo_no_tsv", tsv, v0);
        tick(20);

        // single overrun during RUN
        no_done = 1'b0;
        s0 = starts;
        pps_pulse(7);
        pps_pulse(40);
        chk("ovr_one", overrun_cnt, 1);
        chk("ovr_starts", starts, s0 + 1);

        // five more overruns saturate the 2-bit counter
        no_done = 1'b1;
        pps_pulse(5);
        repeat (5) pps_pulse(5);
        tick(20);
        chk("ovr_sat", overrun_cnt, 3);
        chk("tmo_two", timeout_cnt, 2);

        // clear coincident with an overrun
        pps_pulse(5);
        pps_in = 1'b1;
        tick(2);
        clear_cnt = 1'b1;
        tick(1);
        clear_cnt = 1'b0;
        pps_in = 1'b0;
        tick(1);
        chk("clr_ovr", overrun_cnt, 0);
        chk("clr_tmo", timeout_cnt, 0);
        tick(60);
        chk("clr_then_tmo", timeout_cnt, 1);
        no_done = 1'b0;
        tick(5);

        // reset during START
        pps_in = 1'b1;
        tick(3);
        chk("rs_start", measure_start, 1);
        pps_in = 1'b0;
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        chk("rs_start_low", measure_start, 0);
        chk("rs_busy_low", busy, 0);
        chk("rs_tmo", timeout_cnt, 0);
        chk("rs_ts_sec", ts_sec, 0);
        tick(30);
        pps_in = 1'b1;
        tick(2);
        chk("rs2_start_early", measure_start, 0);
        tick(1);
        chk("rs2_start", measure_start, 1);
        pps_in = 1'b0;
        wait_tsv("rs2");
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
